box_row_sched: RTL and testbench

BOX_ROW_SCHED -- requirements
Module: box_row_sched

---
 rtl/box_row_sched.sv | 95 +++++++++
 tb/tb_box_row_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/box_row_sched.sv
// box_row_sched: streams three host lines into the filter box line buffers and paces one filter run per window
module box_row_sched #(
    parameter int WORDS_PER_LINE = 64,
    parameter int OUT_WORDS = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_num_windows,
    input  logic        i_host_data_valid,
    input  logic [63:0] i_host_data,
    output logic        o_host_data_ack,
    output logic        o_line1_data_valid,
    output logic        o_line2_data_valid,
    output logic        o_line3_data_valid,
    output logic [63:0] o_line_data,
    output logic        o_filter,
    input  logic        i_sobel_data_valid,
    input  logic        i_sobel_data_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_win_count,
    output logic        o_ovf
);
    localparam int LW = 3 * WORDS_PER_LINE;
    localparam int WW = $clog2(LW);
    localparam int OW = $clog2(OUT_WORDS + 1);
    typedef enum logic [2:0] {IDLE, LOAD, FILTER, GAP, DONE} state_t;
    state_t state, state_nx;
    logic [WW-1:0] w;
    logic [OW-1:0] out_cnt;
    logic gap_cnt;
    logic [15:0] num_q;
    logic xfer, hs, start_ok, last_word, last_out;
    assign o_host_data_ack = (state == LOAD) & i_rst;
    assign o_filter = state == FILTER;
    assign o_busy = state != IDLE;
    assign xfer = i_host_data_valid & o_host_data_ack;
    assign hs = i_sobel_data_valid & i_sobel_data_ack;
    assign start_ok = (state == IDLE) & i_start & (i_num_windows != 16'd0);
    assign last_word = w == WW'(LW - 1);
    assign last_out = out_cnt == OW'(OUT_WORDS - 1);
    always_ff @(posedge i_clk) begin
        if (!i_rst)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start) state_nx = (i_num_windows != 16'd0) ? LOAD : DONE;
            LOAD:    if (xfer && last_word) state_nx = FILTER;
            FILTER:  if (hs && last_out) state_nx = GAP;
            GAP:     if (gap_cnt) state_nx = (o_win_count < num_q) ? LOAD : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            w                  <= '0;
            out_cnt            <= '0;
            gap_cnt            <= 1'b0;
            num_q              <= 16'd0;
            o_win_count        <= 16'd0;
            o_ovf              <= 1'b0;
            o_done             <= 1'b0;
            o_line1_data_valid <= 1'b0;
            o_line2_data_valid <= 1'b0;
            o_line3_data_valid <= 1'b0;
            o_line_data        <= 64'd0;
        end else begin
            o_done             <= state == DONE;
            o_line1_data_valid <= xfer && (w < WW'(WORDS_PER_LINE));
            o_line2_data_valid <= xfer && (w >= WW'(WORDS_PER_LINE)) && (w < WW'(2 * WORDS_PER_LINE));
            o_line3_data_valid <= xfer && (w >= WW'(2 * WORDS_PER_LINE));
            gap_cnt            <= (state == GAP) ? ~gap_cnt : 1'b0;
            // result handshakes outside a filter run are flagged, never counted
            o_ovf              <= (o_ovf & ~start_ok) | (hs & (state != FILTER));
            if (xfer) begin
                o_line_data <= i_host_data;
                w           <= last_word ? '0 : w + 1'b1;
            end
            if (start_ok) begin
                num_q       <= i_num_windows;
                o_win_count <= 16'd0;
            end
            if (state == FILTER && hs) begin
                out_cnt <= last_out ? '0 : out_cnt + 1'b1;
                if (last_out) o_win_count <= o_win_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_box_row_sched.sv
// tb_box_row_sched: randomized scoreboard bench for box_row_sched
module tb_box_row_sched;
    localparam int WPL = 64;
    localparam int OUTW = 64;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_num_windows = 16'd0;
    logic        i_host_data_valid = 1'b0;
    logic [63:0] i_host_data = 64'd0;
    logic        i_sobel_data_valid = 1'b0;
    logic        i_sobel_data_ack = 1'b0;
    logic        o_host_data_ack, o_line1_data_valid, o_line2_data_valid, o_line3_data_valid;
    logic [63:0] o_line_data;
    logic        o_filter, o_busy, o_done, o_ovf;
    logic [15:0] o_win_count;

    box_row_sched #(.WORDS_PER_LINE(WPL), .OUT_WORDS(OUTW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_windows(i_num_windows),
        .i_host_data_valid(i_host_data_valid), .i_host_data(i_host_data),
        .o_host_data_ack(o_host_data_ack),
        .o_line1_data_valid(o_line1_data_valid), .o_line2_data_valid(o_line2_data_valid),
        .o_line3_data_valid(o_line3_data_valid), .o_line_data(o_line_data),
        .o_filter(o_filter), .i_sobel_data_valid(i_sobel_data_valid),
        .i_sobel_data_ack(i_sobel_data_ack), .o_busy(o_busy), .o_done(o_done),
        .o_win_count(o_win_count), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { int line; logic [63:0] data; } exp_t;
    exp_t exp_q[$];
    int   done_q[$];
    int   checks = 0;
    int   errors = 0;
    int   lcnt[4];
    int   mon_line;
    int   mon_w;
    exp_t mon_e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "stopped");
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // scoreboard monitor: every strobe and every done pulse consumes one expectation
    always @(negedge i_clk) begin
        if (o_line1_data_valid | o_line2_data_valid | o_line3_data_valid) begin
            mon_line = o_line1_data_valid ? 1 : o_line2_data_valid ? 2 : 3;
            lcnt[mon_line]++;
            chk("strobe_onehot", 128'($countones({o_line1_data_valid, o_line2_data_valid, o_line3_data_valid})), 128'd1);
            chk("strobe_expected", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("strobe_line", 128'(mon_line), 128'(mon_e.line));
                chk("line_data", 128'(o_line_data), 128'(mon_e.data));
            end
        end
        if (o_done) begin
            chk("done_expected", 128'(done_q.size() != 0), 128'd1);
            if (done_q.size() != 0) begin
                mon_w = done_q.pop_front();
                if (mon_w >= 0) chk("done_win_count", 128'(o_win_count), 128'(mon_w));
            end
        end
    end

    task automatic chk_zero(input string name);
        @(negedge i_clk);
        chk(name, {o_host_data_ack, o_line1_data_valid, o_line2_data_valid, o_line3_data_valid,
                   o_line_data, o_filter, o_busy, o_done, o_win_count, o_ovf}, 128'd0);
    endtask

    task automatic start_job(input logic [15:0] n, input bit push, input int exp_win);
        i_start = 1'b1;
        i_num_windows = n;
        if (push) done_q.push_back(exp_win);
        tick();
        i_start = 1'b0;
        i_num_windows = 16'($urandom);
    endtask

    task automatic send_word(input logic [63:0] d, input int gap);
        logic acc;
        int n;
        while ($urandom_range(99) < gap) tick();
        i_host_data_valid = 1'b1;
        i_host_data = d;
        n = 0;
        do begin
            @(negedge i_clk);
            acc = o_host_data_ack;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) timeout("host_ack_wait");
        i_host_data_valid = 1'b0;
    endtask

    task automatic send_words(input int first, input int count, input int gap);
        for (int i = first; i < first + count; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            exp_q.push_back(exp_t'{i / WPL + 1, d});
            send_word(d, gap);
        end
    endtask

    task automatic run_filter(input int gap, input bit last, input bit noise, input bit pulse, input int win_before);
        int n;
        n = 0;
        while (!o_filter && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_filter) timeout("filter_wait");
        tick();
        if (pulse) begin
            i_start = 1'b1;
            i_num_windows = 16'd1;
            tick();
            i_start = 1'b0;
            @(negedge i_clk);
            chk("ignored_start_win_count", 128'(o_win_count), 128'(win_before));
            chk("ignored_start_filter", 128'(o_filter), 128'd1);
            tick();
        end
        for (int i = 0; i < OUTW; i++) begin
            while ($urandom_range(99) < gap) begin
                i_sobel_data_valid = 1'($urandom_range(1));
                i_sobel_data_ack = 1'b0;
                i_host_data_valid = noise;
                i_host_data = {$urandom, $urandom};
                tick();
            end
            i_sobel_data_valid = 1'b1;
            i_sobel_data_ack = 1'b1;
            i_host_data_valid = noise;
            i_host_data = {$urandom, $urandom};
            @(negedge i_clk);
            chk("handshake_in_filter", 128'(o_filter), 128'd1);
            tick();
            i_sobel_data_valid = 1'b0;
            i_sobel_data_ack = 1'b0;
        end
        i_host_data_valid = 1'b0;
        @(negedge i_clk);
        chk("gap1_state", {o_filter, o_busy, o_host_data_ack, o_done}, 128'b0100);
        chk("gap_win_count", 128'(o_win_count), 128'(win_before + 1));
        @(negedge i_clk);
        chk("gap2_state", {o_filter, o_busy, o_host_data_ack, o_done}, 128'b0100);
        @(negedge i_clk);
        if (last) begin
            chk("done_state", {o_filter, o_busy, o_host_data_ack, o_done}, 128'b0100);
            @(negedge i_clk);
            chk("done_pulse", {o_busy, o_done}, 128'b01);
        end else begin
            chk("reload_state", {o_filter, o_busy, o_host_data_ack}, 128'b011);
        end
        tick();
    endtask

    initial begin
        #500000;
        timeout("global_watchdog");
    end

    initial begin
        repeat (3) tick();
        chk_zero("reset_outputs");
        tick();
        i_rst = 1'b1;
        tick();

        // single window, back-to-back host words
        lcnt = '{0, 0, 0, 0};
        start_job(16'd1, 1'b1, 1);
        send_words(0, 3 * WPL, 0);
        @(negedge i_clk);
        chk("filter_after_last_word", {o_filter, o_line3_data_valid}, 128'b11);
        run_filter(0, 1'b1, 1'b0, 1'b0, 0);
        chk("t1_line1_count", 128'(lcnt[1]), 128'(WPL));
        chk("t1_line2_count", 128'(lcnt[2]), 128'(WPL));
        chk("t1_line3_count", 128'(lcnt[3]), 128'(WPL));
        chk("t1_win_count", 128'(o_win_count), 128'd1);
        chk("t1_ovf", 128'(o_ovf), 128'd0);

        // zero-window job completes at once
        start_job(16'd0, 1'b1, -1);
        @(negedge i_clk);
        chk("zero_job_first", {o_done, o_filter, o_busy}, 128'b001);
        @(negedge i_clk);
        chk("zero_job_done", {o_done, o_filter, o_busy}, 128'b100);
        tick();

        // stray result handshake during LOAD
        start_job(16'd1, 1'b1, 1);
        send_words(0, 100, 10);
        i_sobel_data_valid = 1'b1;
        i_sobel_data_ack = 1'b1;
        tick();
        i_sobel_data_valid = 1'b0;
        i_sobel_data_ack = 1'b0;
        @(negedge i_clk);
        chk("ovf_set_in_load", 128'(o_ovf), 128'd1);
        tick();
        send_words(100, 3 * WPL - 100, 10);
        run_filter(10, 1'b1, 1'b0, 1'b0, 0);
        chk("ovf_sticky", 128'(o_ovf), 128'd1);

        // reset in the middle of a load
        start_job(16'd2, 1'b0, 0);
        send_words(0, 100, 20);
        i_rst = 1'b0;
        tick();
        chk_zero("mid_load_reset_outputs");
        tick();
        i_rst = 1'b1;
        chk("reset_scoreboard_drained", 128'(exp_q.size()), 128'd0);
        start_job(16'd1, 1'b1, 1);
        send_words(0, 3 * WPL, 15);
        run_filter(15, 1'b1, 1'b0, 1'b0, 0);

        // three windows with random gaps, host noise and an ignored start
        lcnt = '{0, 0, 0, 0};
        start_job(16'd3, 1'b1, 3);
        for (int k = 0; k < 3; k++) begin
            send_words(0, 3 * WPL, 30);
            run_filter(30, k == 2, 1'b1, k == 0, k);
        end
        chk("t2_strobe_total", 128'(lcnt[1] + lcnt[2] + lcnt[3]), 128'(9 * WPL));
        chk("t2_win_count", 128'(o_win_count), 128'd3);
        chk("t2_ovf", 128'(o_ovf), 128'd0);

        repeat (3) tick();
        chk("exp_q_empty", 128'(exp_q.size()), 128'd0);
        chk("done_q_empty", 128'(done_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
